// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Width helpers size the owner index and the beat counter from the module parameters.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_BURST = 4;

    // A single requester would give clog2 of 0; keep at least one bit.
    function automatic int owner_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int beat_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request searching circularly
// from last_owner+1.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int OW      = owner_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OW-1:0]      last_owner,
    output logic [OW-1:0]      pick,
    output logic               any
);

    int w_best;

    // Rank each request by its circular distance past last_owner; smallest wins.
    always_comb begin
        pick   = '0;
        any    = 1'b0;
        w_best = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req[j] && (((j + NUM_REQ - 1 - int'(last_owner)) % NUM_REQ) < w_best)) begin
                w_best = (j + NUM_REQ - 1 - int'(last_owner)) % NUM_REQ;
                pick   = OW'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ producers,
// granting bounded bursts and honouring the FIFO full flag combinationally.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = DEF_MAX_BURST,
    localparam int OW         = owner_w(NUM_REQ),
    localparam int CW         = beat_w(MAX_BURST)
) (
    input  logic                          wr_clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [OW-1:0]                 owner,
    output logic                          busy
);

    arb_state_t            r_state;
    logic [OW-1:0]         r_owner;
    logic [OW-1:0]         r_last_owner;
    logic [CW-1:0]         r_beat_cnt;

    logic [OW-1:0]         w_pick;
    logic                  w_any;
    logic                  w_req_own;
    logic                  w_last_own;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_accept;
    logic [CW-1:0]         w_beat_nxt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .OW      (OW)
    ) u_rr_pick (
        .req        (req),
        .last_owner (r_last_owner),
        .pick       (w_pick),
        .any        (w_any)
    );

    always_comb begin
        w_req_own  = 1'b0;
        w_last_own = 1'b0;
        w_word     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == OW'(i)) begin
                w_req_own  = req[i];
                w_last_own = req_last[i];
                w_word     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Full is already registered in the FIFO, so gating on it here is safe and
    // never drops a write that the FIFO could have taken.
    assign w_accept   = (r_state == BURST) & w_req_own & ~fifo_full;
    assign w_beat_nxt = r_beat_cnt + CW'(1);

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_accept && (r_owner == OW'(i))) gnt[i] = 1'b1;
        end
    end

    assign fifo_wr_en   = w_accept;
    assign fifo_wr_data = w_accept ? w_word : '0;
    assign owner        = r_owner;
    assign busy         = (r_state == BURST);

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_last_owner <= OW'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner      <= w_pick;
                        r_last_owner <= w_pick;
                        r_beat_cnt   <= '0;
                        r_state      <= BURST;
                    end
                end
                BURST: begin
                    if (!w_req_own) begin
                        r_state <= IDLE;
                    end else if (w_accept) begin
                        r_beat_cnt <= w_beat_nxt;
                        if (w_last_own || (w_beat_nxt == CW'(MAX_BURST))) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random
// traffic, checked every cycle against a behavioural arbitration model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            wr_clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    gnt;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic [1:0]      owner;
    logic            busy;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .wr_clk       (wr_clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .req_last     (req_last),
        .gnt          (gnt),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .owner        (owner),
        .busy         (busy)
    );

    always #5 wr_clk = ~wr_clk;

    // Per-producer word queues: bit 8 is the packet-last flag.
    logic [8:0] q [N][$];
    int         gl_own[$];
    int         gl_cyc[$];
    logic [7:0] rx[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc;

    bit m_busy;
    int m_owner, m_last, m_beats;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                req[i]            = 1'b1;
                req_data[i*DW+:DW] = q[i][0][7:0];
                req_last[i]       = q[i][0][8];
            end else begin
                req[i]            = 1'b0;
                req_data[i*DW+:DW] = '0;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 0; m_last = N - 1; m_beats = 0;
    endtask

    task automatic model_step(input bit acc);
        if (!m_busy) begin
            if (req != '0) begin
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_last + k) % N;
                    if (req[j]) begin
                        m_owner = j; m_last = j; m_beats = 0; m_busy = 1'b1;
                        break;
                    end
                end
            end
        end else if (!req[m_owner]) begin
            m_busy = 1'b0;
        end else if (acc) begin
            m_beats++;
            if (req_last[m_owner] || m_beats == MB) m_busy = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"},  32'(gnt), 0);
        chk({tag, "_wren"}, 32'(fifo_wr_en), 0);
        chk({tag, "_data"}, 32'(fifo_wr_data), 0);
        chk({tag, "_own"},  32'(owner), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // One clock: inputs are applied at posedge+1, checked at negedge, model advances at posedge.
    task automatic cycle();
        bit         acc;
        logic [3:0] eg;
        logic [7:0] ed;
        drive();
        @(negedge wr_clk);
        acc = m_busy && req[m_owner] && !fifo_full;
        eg  = acc ? 4'(1 << m_owner) : 4'h0;
        ed  = acc ? q[m_owner][0][7:0] : 8'h00;
        chk("gnt",     32'(gnt), 32'(eg));
        chk("wr_en",   32'(fifo_wr_en), 32'(acc));
        chk("wr_data", 32'(fifo_wr_data), 32'(ed));
        chk("owner",   32'(owner), 32'(m_owner));
        chk("busy",    32'(busy), 32'(m_busy));
        if (fifo_wr_en) rx.push_back(fifo_wr_data);
        for (int i = 0; i < N; i++) if (gnt[i]) begin gl_own.push_back(i); gl_cyc.push_back(cyc); end
        @(posedge wr_clk);
        cyc++;
        if (acc) void'(q[m_owner].pop_front());
        model_step(acc);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
        gl_own.delete(); gl_cyc.delete(); rx.delete();
        drive();
        #1;
        check_zero("rst");
        @(posedge wr_clk); #1;
        rst_n = 1'b1;
        model_reset();
        cyc = 0;
    endtask

    task automatic push(input int i, input bit last, input logic [7:0] d);
        logic [8:0] e;
        e = {last, d};
        q[i].push_back(e);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Single requester, packet longer than one burst.
        do_reset();
        for (int k = 0; k < 6; k++) push(2, k == 5, 8'(8'h10 + k));
        run(12);
        chk("t1_rx_n", 32'(rx.size()), 6);
        if (rx.size() == 6) for (int k = 0; k < 6; k++) chk("t1_rx", 32'(rx[k]), 32'(8'h10 + k));
        if (gl_cyc.size() == 6) begin
            chk("t1_first", 32'(gl_cyc[0]), 1);
            chk("t1_bubble", 32'(gl_cyc[4] - gl_cyc[3]), 2);
            chk("t1_own", 32'(gl_own[0]), 2);
        end

        // All requesters streaming: 0,1,2,3,0 with four beats and one bubble each.
        do_reset();
        for (int i = 0; i < N; i++) for (int k = 0; k < 30; k++) push(i, 1'b0, 8'(i * 32 + k));
        run(26);
        chk("rr_count", 32'(gl_own.size()), 20);
        if (gl_own.size() >= 20) begin
            for (int b = 0; b < 5; b++)
                for (int w = 0; w < 4; w++) chk("rr_order", 32'(gl_own[b*4+w]), 32'(b % N));
            for (int b = 1; b < 5; b++) chk("rr_bubble", 32'(gl_cyc[b*4] - gl_cyc[b*4-1]), 2);
        end

        // Backpressure after two beats.
        do_reset();
        for (int k = 0; k < 10; k++) push(0, 1'b0, 8'(8'h40 + k));
        run(3);
        fifo_full = 1'b1;
        run(3);
        fifo_full = 1'b0;
        chk("bp_hold", 32'(gl_own.size()), 2);
        run(6);
        if (gl_cyc.size() >= 5) begin
            chk("bp_resume0", 32'(gl_cyc[2]), 6);
            chk("bp_resume1", 32'(gl_cyc[3]), 7);
            chk("bp_bubble", 32'(gl_cyc[4]), 9);
        end else chk("bp_count", 32'(gl_cyc.size()), 5);

        // Withdrawal after one word, then a one-word packet from requester 3.
        do_reset();
        push(1, 1'b0, 8'hA1);
        run(4);
        chk("wd_owner", 32'(owner), 1);
        chk("wd_busy", 32'(busy), 0);
        push(3, 1'b1, 8'hB3);
        push(3, 1'b0, 8'hB4);
        run(5);
        chk("wd_count", 32'(gl_own.size()), 3);
        if (gl_own.size() == 3) begin
            chk("wd_own3", 32'(gl_own[1]), 3);
            chk("wd_last_gap", 32'(gl_cyc[2] - gl_cyc[1]), 2);
            chk("wd_rx", 32'(rx[1]), 32'h B3);
        end

        // Asynchronous reset between edges while requester 1 owns the port.
        do_reset();
        for (int i = 0; i < N; i++) for (int k = 0; k < 30; k++) push(i, 1'b0, 8'(i * 32 + k));
        run(7);
        drive();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("arst");
        @(posedge wr_clk); #1;
        chk("arst_hold", 32'(busy), 0);
        rst_n = 1'b1;
        model_reset();
        gl_own.delete(); gl_cyc.delete();
        cyc = 0;
        run(3);
        if (gl_own.size() > 0) begin
            chk("arst_first_own", 32'(gl_own[0]), 0);
            chk("arst_first_cyc", 32'(gl_cyc[0]), 1);
        end else chk("arst_grant", 0, 1);

        // Random traffic with random backpressure and packet ends.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            fifo_full = ($urandom % 4) == 0;
            for (int i = 0; i < N; i++)
                if (q[i].size() == 0 && ($urandom % 3) == 0) push(i, ($urandom % 4) == 0, 8'($urandom));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the async FIFO among `NUM_REQ` producers in the write-clock domain. It grants one producer at a time for a bounded burst, drives the FIFO's `wr_en`/`wr_data` directly and honours the FIFO's registered `full` flag. It sits between the producer blocks and the FIFO write side; the read side is untouched.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: word width, equal to the FIFO's `DATA_WIDTH`.
- `MAX_BURST`, 4: maximum words accepted per grant, 1..16.
- `wr_clk`  in  1  write-domain clock, the same clock as the FIFO write side.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req`  in  NUM_REQ  per-requester "word available"; held with its data until accepted.
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ  the current word ends the requester's packet.
- `gnt`  out  NUM_REQ  one-hot accept strobe; the word is taken in any cycle where `gnt[i]`=1.
- `fifo_full`  in  1  the FIFO's `full` output.
- `fifo_wr_en`  out  1  the FIFO's `wr_en` input.
- `fifo_wr_data`  out  DATA_WIDTH  the FIFO's `wr_data` input.
- `owner`  out  clog2(NUM_REQ)  index of the current or most recent owner.
- `busy`  out  1  high while in state BURST.

## Operation
- States are IDLE and BURST. The block holds registers `state`, `owner`, `last_owner` and `beat_cnt` (clog2(MAX_BURST+1) bits).
- IDLE: if `req` is non-zero, pick the first set bit searching circularly from `last_owner+1`. Load `owner` and `last_owner` with it, clear `beat_cnt`, and go to BURST. Otherwise stay in IDLE.
- BURST, accept condition: `gnt[owner]` = `req[owner] & !fifo_full`. All other `gnt` bits are 0.
- `fifo_wr_en` = `|gnt`. `fifo_wr_data` = word of `owner` when `fifo_wr_en`=1, else 0. Both are combinational, so the write is never dropped by a stale full.
- On each accept, `beat_cnt` increments.
- Burst terminates and returns to IDLE when any of these holds:
  - an accept carries `req_last[owner]`=1;
  - an accept makes `beat_cnt` reach MAX_BURST;
  - `req[owner]`=0 in a BURST cycle (producer withdrew).
- `fifo_full`=1 in BURST: no accept, `beat_cnt` holds, state holds. There is no timeout.
- `gnt` is always 0 in IDLE.
- Reset mid-burst: words already accepted stay in the FIFO; nothing else is written.
- Reset values: `state`=IDLE, `owner`=0, `last_owner`=NUM_REQ-1 (so requester 0 wins first), `beat_cnt`=0. All outputs are 0.

## Timing
- Arbitration latency: `req` first seen high in IDLE at edge k gives BURST from edge k+1; the first `gnt` can occur in cycle k+1.
- Throughput: one word per cycle within a burst. There is exactly one IDLE bubble cycle between consecutive bursts.
- A requester sees its word consumed at the edge closing a `gnt` cycle. It may present the next word, or drop `req`, in the following cycle.
- `fifo_full` is registered inside the FIFO. The path `fifo_full -> gnt/fifo_wr_en` is combinational and single-cycle.
- Fairness: after owning a grant, a requester is the lowest priority at the next arbitration.
- Worst-case wait with all requesters active and the FIFO not full: (NUM_REQ-1)*(MAX_BURST+1) cycles.

## Structure
- Package `fifo_arb_pkg`:
  - state enum `arb_state_t` {IDLE, BURST};
  - localparam helpers for `owner` and `beat_cnt` widths.
- Sub-module `rr_pick`: purely combinational. Inputs are `req` and `last_owner`; outputs are `pick` index and `any`. It is instantiated once.
- The top module holds the FSM, the counters and the output mux.

## Test plan
- Single requester: reset; `req[2]`=1 with words 0x10..0x15, `req_last` on 0x15. Expect `gnt[2]` on 0x10..0x13 (MAX_BURST=4), one IDLE cycle, then 0x14..0x15. The FIFO receives 0x10..0x15 in order.
- Round robin: all `req`=1 from reset, each requester streaming forever. Grant order is 0,1,2,3,0…, each burst exactly 4 words, one bubble between bursts.
- Full backpressure: force `fifo_full`=1 for 3 cycles mid-burst after 2 beats. No `gnt` or `fifo_wr_en` during those cycles, `beat_cnt` stays 2, and the burst resumes and ends after 2 more words.
- Withdrawal and last: `req[1]` drops after 1 accepted word, giving BURST->IDLE with `owner`=1. A `req_last` on the first word of requester 3 ends its burst after 1 word.
- Async reset: assert `rst_n`=0 between clock edges mid-burst. Outputs go to 0 immediately. After release, the first grant goes to the lowest-index active requester.
